// File: rtl/door_plant_1596.sv
// Purpose : behavioural door plant; integrates motor drive (ml/mr) into a position, decodes end stops, flags abuse.
// Latency : pos/state registered on clk2m; sense_down/sense_up/moving/fault are decodes of that state (no extra delay).
// Backpress: none; the motor inputs are sampled every edge and ignored entirely once in FAULT.
//
// Ports:
//   clk2m       system clock
//   rst         synchronous active-high reset
//   ml          motor left, drives toward closed (pos decrements)
//   mr          motor right, drives toward open (pos increments)
//   sense_down  pos == 0
//   sense_up    pos == TRAVEL_MAX
//   pos         current door position, 0 = closed, TRAVEL_MAX = open
//   moving      door actually travelling this cycle
//   fault       latched mechanical fault, cleared only by rst
//
// RESET_POS must lie in [0, TRAVEL_MAX].
module door_plant_1596 #(
  parameter  int TRAVEL_MAX    = 100,
  parameter  int STEP_DIV      = 2000,
  parameter  int OVERRUN_STEPS = 10,
  parameter  int RESET_POS     = 50,
  localparam int PW            = $clog2(TRAVEL_MAX + 1)
) (
  input  logic          clk2m,
  input  logic          rst,
  input  logic          ml,
  input  logic          mr,
  output logic          sense_down,
  output logic          sense_up,
  output logic [PW-1:0] pos,
  output logic          moving,
  output logic          fault
);

  localparam int SW = $clog2(STEP_DIV + 1);
  localparam int OW = $clog2(OVERRUN_STEPS + 1);

  localparam logic [PW-1:0] POS_MAX    = PW'(TRAVEL_MAX);
  localparam logic [PW-1:0] POS_RST    = PW'(RESET_POS);
  localparam logic [SW-1:0] PRESC_LAST = SW'(STEP_DIV - 1);
  localparam logic [OW-1:0] OVR_LIM    = OW'(OVERRUN_STEPS);

  typedef enum logic [1:0] {
    S_STOPPED,
    S_OPENING,
    S_CLOSING,
    S_FAULT
  } state_t;

  state_t        state;
  logic [SW-1:0] presc;
  logic [OW-1:0] ovr_cnt;

  state_t        tgt_state;
  logic          at_stop;
  logic [OW-1:0] ovr_inc;

  // Direction requested by the single active motor input and whether the
  // door already sits against the end stop in that direction. Only
  // meaningful when exactly one of ml/mr is high.
  always_comb begin
    tgt_state = mr ? S_OPENING : S_CLOSING;
    at_stop   = mr ? (pos == POS_MAX) : (pos == '0);
    ovr_inc   = ovr_cnt + 1'b1;
  end

  always_ff @(posedge clk2m) begin
    if (rst) begin
      state   <= S_STOPPED;
      pos     <= POS_RST;
      presc   <= '0;
      ovr_cnt <= '0;
    end else if (ml && mr) begin
      // Both motors fighting each other: fault from any state.
      state <= S_FAULT;
    end else if (state != S_FAULT) begin
      if (ml || mr) begin
        if (state != tgt_state) begin
          // Entry edge (from STOPPED or a reversal): restart the step
          // period so a partial step in the old direction is discarded.
          state <= tgt_state;
          presc <= '0;
        end else if (presc == PRESC_LAST) begin
          presc <= '0;
          if (!at_stop) begin
            pos     <= mr ? pos + 1'b1 : pos - 1'b1;
            ovr_cnt <= '0;
          end else begin
            // Driving into the stop: pos holds, count the abuse. The
            // counter never passes OVR_LIM because FAULT is terminal.
            ovr_cnt <= ovr_inc;
            if (ovr_inc == OVR_LIM) begin
              state <= S_FAULT;
            end
          end
        end else begin
          presc <= presc + 1'b1;
        end
      end else begin
        state   <= S_STOPPED;
        presc   <= '0;
        ovr_cnt <= '0;
      end
    end
  end

  always_comb begin
    sense_down = (pos == '0);
    sense_up   = (pos == POS_MAX);
    fault      = (state == S_FAULT);
    moving     = ((state == S_OPENING) && (pos != POS_MAX)) ||
                 ((state == S_CLOSING) && (pos != '0));
  end

endmodule

// File: tb/tb_door_plant_1596.sv
module tb_door_plant_1596;

  localparam int TRAVEL_MAX    = 8;
  localparam int STEP_DIV      = 4;
  localparam int OVERRUN_STEPS = 2;
  localparam int RESET_POS     = 4;
  localparam int PW            = $clog2(TRAVEL_MAX + 1);

  logic          clk2m = 1'b0;
  logic          rst;
  logic          ml;
  logic          mr;
  logic          sense_down;
  logic          sense_up;
  logic [PW-1:0] pos;
  logic          moving;
  logic          fault;

  int n_checks = 0;
  int n_fail   = 0;

  door_plant_1596 #(
    .TRAVEL_MAX   (TRAVEL_MAX),
    .STEP_DIV     (STEP_DIV),
    .OVERRUN_STEPS(OVERRUN_STEPS),
    .RESET_POS    (RESET_POS)
  ) dut (
    .clk2m     (clk2m),
    .rst       (rst),
    .ml        (ml),
    .mr        (mr),
    .sense_down(sense_down),
    .sense_up  (sense_up),
    .pos       (pos),
    .moving    (moving),
    .fault     (fault)
  );

  always #5 clk2m = ~clk2m;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // One rising edge, then settle 1 time unit so outputs are sampled and
  // inputs are changed well away from the active edge.
  task automatic tick();
    @(posedge clk2m);
    #1;
  endtask

  task automatic check_all(input string tag, input int e_pos, input int e_mov,
                           input int e_flt);
    check_val({tag, " pos"},    int'(pos),    e_pos);
    check_val({tag, " moving"}, int'(moving), e_mov);
    check_val({tag, " fault"},  int'(fault),  e_flt);
    check_val({tag, " sdown"},  int'(sense_down), (e_pos == 0) ? 1 : 0);
    check_val({tag, " sup"},    int'(sense_up),   (e_pos == TRAVEL_MAX) ? 1 : 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e_pos;

    // 1. Reset for two cycles, then release.
    rst = 1'b1; ml = 1'b0; mr = 1'b0;
    repeat (2) tick();
    check_all("s1_in_reset", 4, 0, 0);
    rst = 1'b0;
    tick();
    check_all("s1_released", 4, 0, 0);

    // 2. mr held: steps land on edges 5/9/13/17, then end stop.
    mr = 1'b1;
    for (int e = 1; e <= 17; e++) begin
      tick();
      e_pos = 4 + (e - 1) / 4;
      check_val($sformatf("s2_e%0d pos", e), int'(pos), e_pos);
      check_val($sformatf("s2_e%0d moving", e), int'(moving), (e <= 16) ? 1 : 0);
      check_val($sformatf("s2_e%0d sup", e), int'(sense_up), (e >= 17) ? 1 : 0);
    end

    // 3. Keep driving into the stop: overrun at 21, fault at 25.
    for (int e = 18; e <= 25; e++) begin
      tick();
      check_val($sformatf("s3_e%0d fault", e), int'(fault), (e >= 25) ? 1 : 0);
      check_val($sformatf("s3_e%0d pos", e), int'(pos), 8);
    end
    check_all("s3_faulted", 8, 0, 1);
    mr = 1'b0;
    repeat (3) tick();
    check_all("s3_release_mr", 8, 0, 1);
    ml = 1'b1;
    repeat (6) tick();
    check_all("s3_ml_ignored", 8, 0, 1);
    ml = 1'b0;

    // 4. Both motors for one edge -> fault, commands then ignored.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all("s4_reset", 4, 0, 0);
    ml = 1'b1; mr = 1'b1;
    tick();
    check_all("s4_both", 4, 0, 1);
    mr = 1'b0;
    repeat (6) tick();
    check_all("s4_ml_ignored", 4, 0, 1);
    ml = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all("s4_cleared", 4, 0, 0);

    // 5. mr for edges 1-3, ml from edge 4: reversal discards partial step.
    mr = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      if (e == 4) begin
        mr = 1'b0;
        ml = 1'b1;
      end
      tick();
      e_pos = (e < 8) ? 4 : 4 - (e - 4) / 4;
      check_val($sformatf("s5_e%0d pos", e), int'(pos), e_pos);
      check_val($sformatf("s5_e%0d sdown", e), int'(sense_down), (e >= 20) ? 1 : 0);
    end
    check_all("s5_closed", 0, 0, 0);
    ml = 1'b0;

    // 6. Reset mid-step with mr still high; stepping restarts cleanly.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mr = 1'b1;
    repeat (9) tick();
    check_all("s6_pos6", 6, 1, 0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    check_all("s6_rst_mid", 4, 0, 0);
    rst = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      tick();
      check_val($sformatf("s6_post_e%0d pos", e), int'(pos), (e >= 5) ? 5 : 4);
      check_val($sformatf("s6_post_e%0d moving", e), int'(moving), 1);
    end
    mr = 1'b0;
    tick();
    check_all("s6_stopped", 5, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
